serial_add_n: RTL and testbench
===============================

# serial_add_n

Bit-serial N-bit adder built around the one-bit full-adder cell (sum = A^B^C_in, carry = majority). It sits downstream of that cell and wraps it with operand shift registers, a carry flip-flop, a bit counter and a start/done handshake. It adds two N-bit operands LSB-first, one bit per clock, and presents the registered N-bit sum, carry-out and signed overflow. It trades N cycles of latency for one adder cell instead of N.

## Interface

- N, default 8: operand width in bits; legal range 1..32.
- CLK  input  1  sole clock, rising-edge active.
- RST  input  1  reset. One clock; reset is synchronous and active-high.
- START  input  1  request to load operands and begin; sampled on CLK rising edge.
- A  input  N  operand A, captured on accepted START only.
- B  input  N  operand B, captured on accepted START only.
- C_in  input  1  carry into bit 0, captured on accepted START only.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse; result registers were updated on this cycle's opening edge.
- Q  output  N  registered sum; holds the last completed result.
- C_out  output  1  registered carry out of bit N-1.
- OVF  output  1  registered signed overflow: carry into bit N-1 XOR carry out of bit N-1.

## Operation

- Internal state:
  - shift registers SA and SB (N bits each);
  - shift register SQ (N bits);
  - carry flop CY;
  - carry-into-MSB flop CM;
  - counter CNT of width clog2(N+1);
  - FSM with states IDLE, RUN, FIN.
- IDLE: BUSY=0. When START=1, load SA=A, SB=B, CY=C_in, CNT=0, and go to RUN.
- RUN: BUSY=1. Each edge does the following:
  - computes s = SA[0]^SB[0]^CY and c = majority(SA[0],SB[0],CY);
  - shifts SA and SB right by one;
  - shifts s into SQ at the MSB, so SQ fills LSB-last and is correctly aligned after N shifts;
  - sets CY = c;
  - when CNT = N-1, also sets CM = CY (the carry into the MSB);
  - increments CNT.
- RUN exit: on the edge where CNT = N-1, go to FIN. On that same edge, Q = final SQ, C_out = c, OVF = CY ^ c. FIN holds DONE=1 and BUSY=0.
- FIN lasts exactly one cycle, then returns to IDLE.
  - START=1 during FIN is accepted, exactly as in IDLE (back-to-back operation).
  - DONE is still 1 for that cycle.
- START during RUN is ignored. Operand inputs are don't-care except on the accepting edge.
- Q, C_out and OVF change only on the completing edge. They hold through IDLE and through the whole of any following run.
- N=1: RUN lasts a single edge. OVF = C_in ^ c.
- Arithmetic is unsigned modulo 2^N, with C_out as bit N. OVF gives the two's-complement overflow of A+B+C_in.

## Timing

- Reset: RST=1 at an edge forces IDLE and sets BUSY=0, DONE=0, Q=0, C_out=0, OVF=0, CNT=0, CY=0. RST has priority over START.
- Reset mid-RUN aborts the operation. No DONE is produced, and outputs return to their reset values.
- Let START be accepted at edge t0.
  - BUSY is high after t0 through the cycle before edge tN.
  - Bit i is processed at edge t(i+1), for i = 0..N-1.
  - The result is registered at edge tN.
  - DONE is high for the single cycle after tN.
- Latency from accepting edge to valid result is N edges. Throughput is one operation every N+1 cycles with back-to-back START.
- No combinational path from inputs to outputs. All outputs are flop-driven.

## Test plan

- Reset: hold RST for 2 edges with START=1 -> BUSY=0, DONE=0, Q=8'h00, C_out=0, OVF=0, and no run starts.
- N=8, A=8'h2B, B=8'h14, C_in=0, START pulse at t0 -> BUSY for 8 cycles; at t8, Q=8'h3F, C_out=0, OVF=0; DONE is high for exactly one cycle.
- A=8'hFF, B=8'h01, C_in=0 -> Q=8'h00, C_out=1, OVF=0. A=8'h7F, B=8'h00, C_in=1 -> Q=8'h80, C_out=0, OVF=1.
- Hold START high continuously with A=8'h80, B=8'h80, C_in=1 -> Q=8'h01, C_out=1, OVF=1.
  - The next run starts in the DONE cycle: DONE pulses every 9 cycles.
  - Operand changes mid-run do not alter the result.
- Assert RST for one edge at t4 of a run (A=8'h55, B=8'hAA) -> no DONE, Q=0. Then run A=8'h55, B=8'hAA, C_in=1 -> Q=8'h00, C_out=1, OVF=0.
- N=1 build, run all 8 combinations of A, B, C_in -> Q and C_out match the full-adder truth table, with DONE one cycle after each accepting edge.

Source files
------------

// File: rtl/serial_add_n.sv
// serial_add_n: bit-serial N-bit adder built on a single full-adder cell.
// Operands are loaded on an accepted START and consumed LSB-first, one bit
// per clock. The sum, carry-out and signed overflow are registered on the
// edge that processes the final bit. DONE then pulses for one cycle.
//
// Handshake: START is a request that is accepted on a rising CLK edge only
// while the block is idle or in its DONE cycle. BUSY=1 means that a request
// would be ignored. DONE=1 means that Q/C_out/OVF were refreshed on the edge
// that opened this cycle. A START that is high during DONE is accepted
// immediately, so back-to-back operations take N+1 cycles each.
module serial_add_n #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] Q,
    output logic         C_out,
    output logic         OVF,
    output logic [1:0]   state_dbg,
    output logic         cm_dbg
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          accept;

    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  sq;
    logic          cy;
    logic          cm;
    logic [CW-1:0] cnt;

    logic          s_bit;
    logic          c_bit;
    logic          last_bit;
    logic [N:0]    sq_cat;
    logic [N-1:0]  sq_nx;

    // Full-adder cell on the current LSBs plus the sum shift-in value.
    always_comb begin
        s_bit    = sa[0] ^ sb[0] ^ cy;
        c_bit    = (sa[0] & sb[0]) | (sa[0] & cy) | (sb[0] & cy);
        // Concatenate and drop the LSB so the N=1 build needs no special case.
        sq_cat   = {s_bit, sq};
        sq_nx    = sq_cat[N:1];
        last_bit = (cnt == CW'(N - 1));
    end

    // Next-state logic. A START is accepted in IDLE and in the DONE cycle.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                if (START) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand/sum shift registers, carries, bit counter and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sa    <= '0;
            sb    <= '0;
            sq    <= '0;
            cy    <= 1'b0;
            cm    <= 1'b0;
            cnt   <= '0;
            Q     <= '0;
            C_out <= 1'b0;
            OVF   <= 1'b0;
        end else if (accept) begin
            sa  <= A;
            sb  <= B;
            cy  <= C_in;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sq  <= sq_nx;
            cy  <= c_bit;
            cnt <= cnt + 1'b1;
            if (last_bit) begin
                // cy currently holds the carry into the MSB.
                cm    <= cy;
                Q     <= sq_nx;
                C_out <= c_bit;
                OVF   <= cy ^ c_bit;
            end
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BUSY <= 1'b0;
            DONE <= 1'b0;
        end else begin
            BUSY <= (state_nx == RUN);
            DONE <= (state_nx == FIN);
        end
    end

    // Debug view of the FSM and the stored carry into the MSB.
    always_comb begin
        state_dbg = state;
        cm_dbg    = cm;
    end

endmodule

// File: tb/tb_serial_add_n.sv
// tb_serial_add_n: directed checks of serial_add_n with an N=8 instance and an
// N=1 instance sharing one clock and reset.
module tb_serial_add_n;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] q8;
    logic       cout8;
    logic       ovf8;
    logic [1:0] st8;
    logic       cm8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] q1;
    logic       cout1;
    logic       ovf1;
    logic [1:0] st1;
    logic       cm1;

    int n_pass  = 0;
    int n_total = 0;

    serial_add_n #(.N(8)) dut8 (
        .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8), .C_in(cin8),
        .BUSY(busy8), .DONE(done8), .Q(q8), .C_out(cout8), .OVF(ovf8),
        .state_dbg(st8), .cm_dbg(cm8)
    );

    serial_add_n #(.N(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1), .C_in(cin1),
        .BUSY(busy1), .DONE(done1), .Q(q1), .C_out(cout1), .OVF(ovf1),
        .state_dbg(st1), .cm_dbg(cm1)
    );

    // Clock: rising edges at 5, 15, 25 ...; inputs driven and outputs sampled on falling edges.
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One N=8 operation: checks latency, BUSY length, result hold and one-cycle DONE.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] eq, input logic ec, input logic eo);
        int         cyc;
        int         busy_cyc;
        logic [7:0] q_before;
        logic       held;
        @(negedge clk);
        start8   = 1'b1;
        a8       = a;
        b8       = b;
        cin8     = c;
        q_before = q8;
        @(negedge clk);
        start8   = 1'b0;
        a8       = 8'($urandom);
        b8       = 8'($urandom);
        cin8     = 1'($urandom_range(0, 1));
        cyc      = 0;
        busy_cyc = 0;
        held     = 1'b1;
        while (!done8 && cyc < 20) begin
            if (busy8) busy_cyc++;
            if (q8 !== q_before) held = 1'b0;
            @(negedge clk);
            cyc++;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
        check({tag, "_done"},    32'(done8), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'd8);
        check({tag, "_busy_len"}, 32'(busy_cyc), 32'd8);
        check({tag, "_q_held"},  32'(held), 32'd1);
        check({tag, "_busy_fin"}, 32'(busy8), 32'd0);
        check({tag, "_q"},       32'(q8), 32'(eq));
        check({tag, "_cout"},    32'(cout8), 32'(ec));
        check({tag, "_ovf"},     32'(ovf8), 32'(eo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int         cyc;
        int         ndone;
        int         last;
        logic       seen;
        logic [7:0] fa_sum;
        logic [7:0] fa_cry;
        logic       ec;

        // Reset held for two edges with START high on both instances.
        rst    = 1'b1;
        start8 = 1'b1;
        a8     = 8'h2B;
        b8     = 8'h14;
        cin8   = 1'b1;
        start1 = 1'b1;
        a1     = 1'b1;
        b1     = 1'b1;
        cin1   = 1'b1;
        @(negedge clk);
        check("rst1_busy", 32'(busy8), 32'd0);
        check("rst1_done", 32'(done8), 32'd0);
        @(negedge clk);
        check("rst2_busy", 32'(busy8), 32'd0);
        check("rst2_done", 32'(done8), 32'd0);
        check("rst2_q",    32'(q8), 32'h00);
        check("rst2_cout", 32'(cout8), 32'd0);
        check("rst2_ovf",  32'(ovf8), 32'd0);
        check("rst2_state", 32'(st8), 32'd0);
        check("rst2_busy1", 32'(busy1), 32'd0);
        check("rst2_q1",   32'(q1), 32'd0);
        rst    = 1'b0;
        start8 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy8), 32'd0);
        check("post_rst_idle1", 32'(busy1), 32'd0);

        // Single directed operations.
        run8("add_2b_14", 8'h2B, 8'h14, 1'b0, 8'h3F, 1'b0, 1'b0);
        run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("add_7f_00", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

        // START held high: back-to-back runs, operands scrambled mid-run.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h80;
        b8     = 8'h80;
        cin8   = 1'b1;
        cyc    = 0;
        ndone  = 0;
        last   = 0;
        while (ndone < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                check("b2b_q",    32'(q8), 32'h01);
                check("b2b_cout", 32'(cout8), 32'd1);
                check("b2b_ovf",  32'(ovf8), 32'd1);
                if (ndone == 0) check("b2b_first_latency", 32'(cyc), 32'd9);
                else check("b2b_spacing", 32'(cyc - last), 32'd9);
                last = cyc;
                ndone++;
                a8   = 8'h80;
                b8   = 8'h80;
                cin8 = 1'b1;
                if (ndone == 3) start8 = 1'b0;
            end else begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                cin8 = 1'($urandom_range(0, 1));
            end
        end
        check("b2b_count", 32'(ndone), 32'd3);
        @(negedge clk);
        check("b2b_back_idle", 32'(busy8), 32'd0);

        // Reset in the middle of a run (RST high at the fourth processing edge).
        start8 = 1'b1;
        a8     = 8'h55;
        b8     = 8'hAA;
        cin8   = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_q",    32'(q8), 32'h00);
        check("abort_cout", 32'(cout8), 32'd0);
        check("abort_ovf",  32'(ovf8), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        run8("add_55_aa_c1", 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);

        // N=1 instance: full-adder truth table indexed by {a,b,c_in}.
        fa_sum = 8'b1001_0110;
        fa_cry = 8'b1110_1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("n1_%0d_idle_done", k), 32'(done1), 32'd0);
            start1 = 1'b1;
            a1     = 1'(k >> 2);
            b1     = 1'(k >> 1);
            cin1   = 1'(k);
            @(negedge clk);
            start1 = 1'b0;
            a1     = 1'($urandom_range(0, 1));
            b1     = 1'($urandom_range(0, 1));
            check($sformatf("n1_%0d_busy", k), 32'(busy1), 32'd1);
            check($sformatf("n1_%0d_early_done", k), 32'(done1), 32'd0);
            @(negedge clk);
            ec = fa_cry[k];
            check($sformatf("n1_%0d_done", k), 32'(done1), 32'd1);
            check($sformatf("n1_%0d_q", k), 32'(q1), 32'(fa_sum[k]));
            check($sformatf("n1_%0d_cout", k), 32'(cout1), 32'(ec));
            check($sformatf("n1_%0d_ovf", k), 32'(ovf1), 32'(ec ^ k[0]));
        end
        @(negedge clk);
        check("n1_final_done", 32'(done1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
